flint_lsu: RTL and testbench

//  Parametrised load/store unit for the flintRV memory stage; replaces the

---
 rtl/flint_lsu_pkg.sv | 28 ++
 rtl/flint_lsu_tracker.sv | 53 +++++
 rtl/flint_lsu.sv | 158 +++++++++++++++
 tb/tb_flint_lsu.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flint_lsu_pkg.sv
// flintRV load/store unit shared types.
// Funct3 codes, exception causes and the load tracker entry.
package flint_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam logic [1:0] EXC_LD_MISAL = 2'b01;
    localparam logic [1:0] EXC_ST_MISAL = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [2:0] off;
    } ld_entry_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/flint_lsu_tracker.sv
// In-order FIFO of outstanding loads awaiting a bus response.
// A pop frees a slot for a push in the same cycle.
module flint_lsu_tracker
    import flint_lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ld_entry_t push_data,
    input  logic      pop,
    output ld_entry_t pop_data,
    output logic [2:0] count,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ld_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic full;
    logic do_push;
    logic do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == 3'(DEPTH));
    assign empty    = (count == 3'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/flint_lsu.sv
// Load/store unit: aligns and issues MEM-stage accesses on a valid/ready
// bus, tracks outstanding loads and returns extended results in order.
module flint_lsu
    import flint_lsu_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [4:0]        i_req_rd,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [XLEN-1:0]   o_wb_data,
    output logic              o_exc_valid,
    output logic [1:0]        o_exc_cause,
    output logic [XLEN-1:0]   o_exc_addr,
    output logic              o_resp_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [OFFW-1:0] off;
    logic [3:0]      nbytes;
    logic [2:0]      amask;
    logic            misal;
    logic            illegal;
    logic            bad;
    logic            accept;
    logic            push;
    logic            pop;
    logic            empty;
    logic [2:0]      count;
    ld_entry_t       push_e;
    ld_entry_t       head;
    logic [NB-1:0]   strb_base;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ext;

    assign off     = i_req_addr[OFFW-1:0];
    assign nbytes  = size_bytes(i_req_funct3);
    assign amask   = 3'(nbytes - 4'd1);
    assign misal   = (i_req_addr[2:0] & amask) != 3'd0;
    assign illegal = (i_req_funct3 == F3_BAD) ||
                     (XLEN == 32 && (i_req_funct3 == F3_D ||
                                     i_req_funct3 == F3_WU));
    assign bad     = illegal || misal;

    // Reset also holds ready low so nothing is accepted while in reset.
    assign o_req_ready = i_rst_n && (!o_mem_valid || i_mem_ready) &&
                         (i_req_store || count < 3'(MAX_OUTSTANDING));
    assign accept = i_req_valid && o_req_ready;
    assign push   = accept && !i_req_store && !bad;
    assign pop    = i_mem_rvalid && !empty;
    assign push_e = '{rd: i_req_rd, funct3: i_req_funct3, off: 3'(off)};

    always_comb begin
        strb_base = '0;
        case (i_req_funct3[1:0])
            2'b00:   strb_base = NB'(8'h01);
            2'b01:   strb_base = NB'(8'h03);
            2'b10:   strb_base = NB'(8'h0f);
            default: strb_base = NB'(8'hff);
        endcase
    end

    assign strb  = strb_base << off;
    assign wdata = i_req_wdata << {off, 3'b000};

    flint_lsu_tracker #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (push_e),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_valid <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wstrb <= '0;
            o_mem_wdata <= '0;
            o_exc_valid <= 1'b0;
            o_exc_cause <= 2'b00;
            o_exc_addr  <= '0;
        end else begin
            if (accept && !bad) begin
                o_mem_valid <= 1'b1;
                o_mem_we    <= i_req_store;
                o_mem_addr  <= {i_req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                o_mem_wstrb <= i_req_store ? strb : '0;
                o_mem_wdata <= i_req_store ? wdata : '0;
            end else if (i_mem_ready) begin
                o_mem_valid <= 1'b0;
            end
            o_exc_valid <= accept && bad;
            if (accept && bad) begin
                o_exc_cause <= illegal ? EXC_ILLEGAL :
                               (i_req_store ? EXC_ST_MISAL : EXC_LD_MISAL);
                o_exc_addr  <= i_req_addr;
            end
        end
    end

    assign sh = i_mem_rdata >> {head.off, 3'b000};

    always_comb begin
        ext = sh;
        case (head.funct3)
            F3_B:    ext = XLEN'($signed(sh[7:0]));
            F3_H:    ext = XLEN'($signed(sh[15:0]));
            F3_W:    ext = XLEN'($signed(sh[31:0]));
            F3_BU:   ext = XLEN'(sh[7:0]);
            F3_HU:   ext = XLEN'(sh[15:0]);
            F3_WU:   ext = XLEN'(sh[31:0]);
            default: ext = sh;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_valid <= 1'b0;
            o_wb_rd    <= 5'd0;
            o_wb_data  <= '0;
            o_resp_err <= 1'b0;
        end else begin
            o_wb_valid <= pop;
            if (pop) begin
                o_wb_rd   <= head.rd;
                o_wb_data <= ext;
            end
            if (i_mem_rvalid && empty) o_resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flint_lsu.sv
// Directed bench for flint_lsu: a 32-bit instance for the main paths
// and a 64-bit instance for doubleword and LWU handling.
module tb_flint_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        resp_err;

    logic        v64 = 1'b0;
    logic        rdy64;
    logic [2:0]  f3_64 = 3'd0;
    logic [63:0] a64 = 64'd0;
    logic [4:0]  rd64 = 5'd0;
    logic        mv64;
    logic        mwe64;
    logic [63:0] ma64;
    logic [7:0]  ms64;
    logic [63:0] mw64;
    logic        rv64 = 1'b0;
    logic [63:0] rdat64 = 64'd0;
    logic        wbv64;
    logic [4:0]  wbrd64;
    logic [63:0] wbd64;
    logic        ev64;
    logic [1:0]  ec64;
    logic [63:0] ea64;
    logic        re64;

    int n_tests = 0;
    int n_fail  = 0;

    flint_lsu #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_store  (req_store),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_rd     (req_rd),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wstrb  (mem_wstrb),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_wb_valid   (wb_valid),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_exc_valid  (exc_valid),
        .o_exc_cause  (exc_cause),
        .o_exc_addr   (exc_addr),
        .o_resp_err   (resp_err)
    );

    flint_lsu #(.XLEN(64), .MAX_OUTSTANDING(2)) dut64 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (v64),
        .o_req_ready  (rdy64),
        .i_req_store  (1'b0),
        .i_req_funct3 (f3_64),
        .i_req_addr   (a64),
        .i_req_wdata  (64'd0),
        .i_req_rd     (rd64),
        .o_mem_valid  (mv64),
        .i_mem_ready  (1'b1),
        .o_mem_we     (mwe64),
        .o_mem_addr   (ma64),
        .o_mem_wstrb  (ms64),
        .o_mem_wdata  (mw64),
        .i_mem_rvalid (rv64),
        .i_mem_rdata  (rdat64),
        .o_wb_valid   (wbv64),
        .o_wb_rd      (wbrd64),
        .o_wb_data    (wbd64),
        .o_exc_valid  (ev64),
        .o_exc_cause  (ec64),
        .o_exc_addr   (ea64),
        .o_resp_err   (re64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rdata  = d;
        mem_rvalid = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_exc_valid", 64'(exc_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        cyc();

        // SW word
        put(1'b1, 3'b010, 32'h104, 32'hdeadbeef, 5'd0);
        cyc();
        idle();
        check("sw_valid", 64'(mem_valid), 64'd1);
        check("sw_we", 64'(mem_we), 64'd1);
        check("sw_addr", 64'(mem_addr), 64'h104);
        check("sw_strb", 64'(mem_wstrb), 64'hf);
        check("sw_wdata", 64'(mem_wdata), 64'hdeadbeef);

        // SB to top lane
        put(1'b1, 3'b000, 32'h103, 32'h5a, 5'd0);
        cyc();
        idle();
        check("sb_addr", 64'(mem_addr), 64'h100);
        check("sb_strb", 64'(mem_wstrb), 64'h8);
        check("sb_wdata", 64'(mem_wdata), 64'h5a000000);

        // misaligned SH
        put(1'b1, 3'b001, 32'h103, 32'h1234, 5'd0);
        cyc();
        idle();
        check("sh_exc_valid", 64'(exc_valid), 64'd1);
        check("sh_exc_cause", 64'(exc_cause), 64'd2);
        check("sh_exc_addr", 64'(exc_addr), 64'h103);
        check("sh_no_mem", 64'(mem_valid), 64'd0);
        cyc();
        check("sh_exc_pulse", 64'(exc_valid), 64'd0);
        check("sh_still_no_mem", 64'(mem_valid), 64'd0);

        // LB sign-extended
        put(1'b0, 3'b000, 32'h102, 32'd0, 5'd7);
        cyc();
        idle();
        check("lb_valid", 64'(mem_valid), 64'd1);
        check("lb_we", 64'(mem_we), 64'd0);
        check("lb_addr", 64'(mem_addr), 64'h100);
        respond(32'h00800000);
        check("lb_wb_valid", 64'(wb_valid), 64'd1);
        check("lb_wb_rd", 64'(wb_rd), 64'd7);
        check("lb_wb_data", 64'(wb_data), 64'hffffff80);
        cyc();
        check("lb_wb_pulse", 64'(wb_valid), 64'd0);

        // LBU zero-extended
        put(1'b0, 3'b100, 32'h102, 32'd0, 5'd7);
        cyc();
        idle();
        respond(32'h00800000);
        check("lbu_wb_data", 64'(wb_data), 64'h00000080);

        // three LW, third held until a response frees a slot
        put(1'b0, 3'b010, 32'h200, 32'd0, 5'd1);
        cyc();
        put(1'b0, 3'b010, 32'h204, 32'd0, 5'd2);
        cyc();
        put(1'b0, 3'b010, 32'h208, 32'd0, 5'd3);
        check("lw3_ready0", 64'(req_ready), 64'd0);
        cyc();
        check("lw3_ready0_hold", 64'(req_ready), 64'd0);
        check("lw_mem_addr2", 64'(mem_addr), 64'h204);
        respond(32'h11111111);
        check("lw1_wb_rd", 64'(wb_rd), 64'd1);
        check("lw1_wb_data", 64'(wb_data), 64'h11111111);
        check("lw3_ready1", 64'(req_ready), 64'd1);
        cyc();
        idle();
        check("lw3_issued", 64'(mem_addr), 64'h208);
        respond(32'h22222222);
        check("lw2_wb_rd", 64'(wb_rd), 64'd2);
        check("lw2_wb_data", 64'(wb_data), 64'h22222222);
        respond(32'h33333333);
        check("lw3_wb_rd", 64'(wb_rd), 64'd3);
        check("lw3_wb_data", 64'(wb_data), 64'h33333333);

        // bus stall holds the request stable
        mem_ready = 1'b0;
        put(1'b1, 3'b010, 32'h40, 32'h12345678, 5'd0);
        cyc();
        idle();
        check("stall_ready0", 64'(req_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(mem_valid), 64'd1);
            check("stall_addr", 64'(mem_addr), 64'h40);
            check("stall_wdata", 64'(mem_wdata), 64'h12345678);
            check("stall_strb", 64'(mem_wstrb), 64'hf);
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        check("stall_release", 64'(mem_valid), 64'd0);

        // reset mid-operation, then a late response
        mem_ready = 1'b0;
        put(1'b0, 3'b010, 32'h300, 32'd0, 5'd9);
        cyc();
        idle();
        check("pre_rst_valid", 64'(mem_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        cyc();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        respond(32'hcafef00d);
        check("late_wb_valid", 64'(wb_valid), 64'd0);
        check("late_resp_err", 64'(resp_err), 64'd1);
        cyc();
        cyc();
        check("resp_err_sticky", 64'(resp_err), 64'd1);

        // LD illegal on 32-bit
        put(1'b0, 3'b011, 32'h8, 32'd0, 5'd3);
        cyc();
        idle();
        check("ld32_exc_valid", 64'(exc_valid), 64'd1);
        check("ld32_exc_cause", 64'(exc_cause), 64'd3);
        check("ld32_exc_addr", 64'(exc_addr), 64'h8);
        check("ld32_no_mem", 64'(mem_valid), 64'd0);

        // 64-bit LD passthrough
        v64 = 1'b1;
        f3_64 = 3'b011;
        a64 = 64'h8;
        rd64 = 5'd4;
        cyc();
        v64 = 1'b0;
        check("ld64_valid", 64'(mv64), 64'd1);
        check("ld64_addr", ma64, 64'h8);
        rdat64 = 64'h0123456789abcdef;
        rv64 = 1'b1;
        cyc();
        rv64 = 1'b0;
        check("ld64_wb_valid", 64'(wbv64), 64'd1);
        check("ld64_wb_rd", 64'(wbrd64), 64'd4);
        check("ld64_wb_data", wbd64, 64'h0123456789abcdef);

        // 64-bit LWU and LW of the same word
        v64 = 1'b1;
        f3_64 = 3'b110;
        a64 = 64'h10;
        rd64 = 5'd5;
        cyc();
        v64 = 1'b0;
        rdat64 = 64'h0000000080000000;
        rv64 = 1'b1;
        cyc();
        rv64 = 1'b0;
        check("lwu64_wb_data", wbd64, 64'h0000000080000000);
        v64 = 1'b1;
        f3_64 = 3'b010;
        cyc();
        v64 = 1'b0;
        rv64 = 1'b1;
        cyc();
        rv64 = 1'b0;
        check("lw64_wb_data", wbd64, 64'hffffffff80000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
